mc_ctrl_fsm: RTL and testbench

Parametrised multi-cycle MIPS control FSM, successor to the fixed-timing control unit. It sits beside the multi-cycle datapath and drives the same control bundle. It adds a memory-ready handshake with a configurable timeout, BNE/ADDI/J support, and illegal-opcode and timeout fault detection. Optional performance counters are included.

---
 rtl/mc_ctrl_if.sv | 45 ++++
 rtl/mc_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control bundle between the multi-cycle MIPS control FSM and its datapath.
// Carries the datapath status inputs (opc, Zero, mem_ready), the datapath control
// outputs, the sticky fault flag, the debug state and the performance counters.
//   master: datapath / environment side (drives opc, Zero, mem_ready)
//   slave : control FSM side (drives controls, fault, state_o, counters)
interface mc_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opc;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteControl;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             RegDst;
  logic             ALUSelA;
  logic             TargetWrite;
  logic [1:0]       ALUSelB;
  logic [1:0]       PCSrc;
  logic [1:0]       ALUOp;
  logic             fault;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output opc, Zero, mem_ready,
    input  PCWrite, PCWriteControl, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSelA, TargetWrite, ALUSelB, PCSrc, ALUOp,
           fault, state_o, instr_cnt, cycle_cnt, stall_cnt
  );

  modport slave (
    input  opc, Zero, mem_ready,
    output PCWrite, PCWriteControl, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSelA, TargetWrite, ALUSelB, PCSrc, ALUOp,
           fault, state_o, instr_cnt, cycle_cnt, stall_cnt
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM with memory-ready handshake, wait timeout,
// BEQ/BNE/ADDI/J support and sticky fault on illegal opcode or memory timeout.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-low reset
//   bus   - mc_ctrl_if.slave: opc/Zero/mem_ready in; controls, fault, state_o,
//           instr_cnt/cycle_cnt/stall_cnt out
// Parameters: TMO_CYCLES (max consecutive not-ready cycles, 0 = no timeout), CNT_W.
// Optional: define MC_CTRL_PERF_EN to build the performance counters; otherwise the
// counter ports are tied to zero.
module mc_ctrl_fsm #(
  parameter int unsigned TMO_CYCLES = 255,
  parameter int unsigned CNT_W      = 32
) (
  input logic     clk,
  input logic     reset,
  mc_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES + 1) : 1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_FAULT  = 4'd15
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              op_sw;
  logic              op_bne;
  logic              tmo_hit;

  // Timeout fires only when the wait counter has reached the limit and the timeout is enabled.
  assign tmo_hit = (TMO_CYCLES != 0) && (wait_cnt == WAIT_W'(TMO_CYCLES));

  // State register, wait counter and opcode latch. The wait counter is only non-zero
  // while dwelling in a memory-wait state, so it is cleared on every transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      op_sw    <= 1'b0;
      op_bne   <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_FETCH: begin
          if (bus.mem_ready)  state <= S_DECODE;
          else if (tmo_hit)   state <= S_FAULT;
          else                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_DECODE: begin
          op_sw  <= (bus.opc == OP_SW);
          op_bne <= (bus.opc == OP_BNE);
          case (bus.opc)
            OP_LW, OP_SW:   state <= S_MEMADR;
            OP_R:           state <= S_EXEC;
            OP_BEQ, OP_BNE: state <= S_BRANCH;
            OP_J:           state <= S_JUMP;
            OP_ADDI:        state <= S_ADDIEX;
            default:        state <= S_FAULT;
          endcase
        end
        S_MEMADR: state <= op_sw ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (bus.mem_ready)  state <= S_MEMWB;
          else if (tmo_hit)   state <= S_FAULT;
          else                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR: begin
          if (bus.mem_ready)  state <= S_FETCH;
          else if (tmo_hit)   state <= S_FAULT;
          else                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_EXEC:   state <= S_RWB;
        S_RWB:    state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
        S_FAULT:  state <= S_FAULT;
        default:  state <= S_FAULT;
      endcase
    end
  end

  logic       pc_write, pc_write_control, iord, mem_read, mem_write, ir_write;
  logic       memto_reg, reg_write, reg_dst, alu_sel_a, target_write;
  logic [1:0] alu_sel_b, pc_src, alu_op;

  // Moore control decode from the registered state; everything is held at 0 while reset is low.
  always_comb begin
    pc_write         = 1'b0;
    pc_write_control = 1'b0;
    iord             = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    memto_reg        = 1'b0;
    reg_write        = 1'b0;
    reg_dst          = 1'b0;
    alu_sel_a        = 1'b0;
    target_write     = 1'b0;
    alu_sel_b        = 2'b00;
    pc_src           = 2'b00;
    alu_op           = 2'b00;
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_sel_b = 2'b01;
          ir_write  = bus.mem_ready;
          pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          alu_sel_b    = 2'b11;
          target_write = 1'b1;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_sel_a = 1'b1;
          alu_sel_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write = 1'b1;
          memto_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXEC: begin
          alu_sel_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_sel_a        = 1'b1;
          alu_op           = 2'b01;
          pc_src           = 2'b01;
          // Branch sense comes from the opcode captured in DECODE.
          pc_write_control = op_bne ? ~bus.Zero : bus.Zero;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_ADDIWB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.PCWrite        = pc_write;
  assign bus.PCWriteControl = pc_write_control;
  assign bus.IorD           = iord;
  assign bus.MemRead        = mem_read;
  assign bus.MemWrite       = mem_write;
  assign bus.IRWrite        = ir_write;
  assign bus.MemtoReg       = memto_reg;
  assign bus.RegWrite       = reg_write;
  assign bus.RegDst         = reg_dst;
  assign bus.ALUSelA        = alu_sel_a;
  assign bus.TargetWrite    = target_write;
  assign bus.ALUSelB        = alu_sel_b;
  assign bus.PCSrc          = pc_src;
  assign bus.ALUOp          = alu_op;
  assign bus.fault          = (state == S_FAULT);
  assign bus.state_o        = state;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] instr_q, cycle_q, stall_q;
  logic             wait_state;

  assign wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  // Performance counters; they wrap naturally and freeze once the FSM has faulted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= '0;
      cycle_q <= '0;
      stall_q <= '0;
    end else if (state != S_FAULT) begin
      cycle_q <= cycle_q + CNT_W'(1);
      if ((state == S_FETCH) && bus.mem_ready) instr_q <= instr_q + CNT_W'(1);
      if (wait_state && !bus.mem_ready)        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.instr_cnt = instr_q;
  assign bus.cycle_cnt = cycle_q;
  assign bus.stall_cnt = stall_q;
`else
  assign bus.instr_cnt = CNT_W'(0);
  assign bus.cycle_cnt = CNT_W'(0);
  assign bus.stall_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: self-checking bench for mc_ctrl_fsm. Each instruction is expanded into
// its expected per-cycle phase list (state, mem_ready driven, expected controls) from the
// instruction-level rules, then applied and compared cycle by cycle. Counters are modelled
// from per-cycle events. Timeout limit is 4 cycles for this bench.
module tb_mc_ctrl_fsm;

  localparam int unsigned TMO   = 4;
  localparam int unsigned CNT_W = 32;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       pc_write, pc_write_control, iord, mem_read, mem_write, ir_write;
    logic       memto_reg, reg_write, reg_dst, alu_sel_a, target_write;
    logic [1:0] alu_sel_b, pc_src, alu_op;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset;

  mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mc_ctrl_fsm #(.TMO_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_cycle, m_instr, m_stall;

  ctrl_t obs_c;
  assign obs_c = {bus.PCWrite, bus.PCWriteControl, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.RegDst, bus.ALUSelA,
                  bus.TargetWrite, bus.ALUSelB, bus.PCSrc, bus.ALUOp};

  // Expected control bundle for one phase (numbered as the debug state).
  function automatic ctrl_t exp_ctrl(input int ph, input logic rdy, input logic pcwc);
    ctrl_t c;
    c = '0;
    case (ph)
      0:  begin c.mem_read = 1; c.alu_sel_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1:  begin c.alu_sel_b = 2'b11; c.target_write = 1; end
      2:  begin c.alu_sel_a = 1; c.alu_sel_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.memto_reg = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_sel_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_sel_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_write_control = pcwc; end
      9:  begin c.pc_write = 1; c.pc_src = 2'b10; end
      10: begin c.alu_sel_a = 1; c.alu_sel_b = 2'b10; end
      11: begin c.reg_write = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Hold reset low for n cycles; controls must be 0 throughout, state/fault cleared after the first edge.
  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      reset         = 1'b0;
      bus.mem_ready = 1'($urandom);
      bus.opc       = 6'($urandom);
      bus.Zero      = 1'($urandom);
      #1;
      n_vec++;
      if (obs_c !== ctrl_t'(0)) begin
        n_err++;
        $display("FAIL reset_ctrl cyc%0d: got %h want 0", c, obs_c);
      end
      if (c > 0) begin
        n_vec++;
        if (bus.state_o !== 4'd0 || bus.fault !== 1'b0) begin
          n_err++;
          $display("FAIL reset_state cyc%0d: got state %0d fault %b want 0/0", c, bus.state_o, bus.fault);
        end
      end
    end
    m_cycle = 0;
    m_instr = 0;
    m_stall = 0;
  endtask

  // Expand one instruction into phases and apply/check it. abort_at >= 0 stops early;
  // tmo builds a FETCH that never sees mem_ready.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic zero,
                           input int abort_at, input bit tmo);
    int   ph[$];
    bit   rd[$];
    int   dec_idx;
    logic pcwc;
    logic [31:0] e_c, e_i, e_s;
    pcwc = (op == OP_BNE) ? ~zero : zero;
    if (tmo) begin
      repeat (TMO + 1) begin ph.push_back(0); rd.push_back(1'b0); end
      repeat (4)       begin ph.push_back(15); rd.push_back(1'b1); end
      dec_idx = 1000;
    end else begin
      repeat (fw) begin ph.push_back(0); rd.push_back(1'b0); end
      ph.push_back(0); rd.push_back(1'b1);
      ph.push_back(1); rd.push_back(1'($urandom));
      dec_idx = fw + 1;
      case (op)
        OP_LW: begin
          ph.push_back(2); rd.push_back(1'($urandom));
          repeat (mw) begin ph.push_back(3); rd.push_back(1'b0); end
          ph.push_back(3); rd.push_back(1'b1);
          ph.push_back(4); rd.push_back(1'($urandom));
        end
        OP_SW: begin
          ph.push_back(2); rd.push_back(1'($urandom));
          repeat (mw) begin ph.push_back(5); rd.push_back(1'b0); end
          ph.push_back(5); rd.push_back(1'b1);
        end
        OP_R: begin
          ph.push_back(6); rd.push_back(1'($urandom));
          ph.push_back(7); rd.push_back(1'($urandom));
        end
        OP_BEQ, OP_BNE: begin ph.push_back(8); rd.push_back(1'($urandom)); end
        OP_J:           begin ph.push_back(9); rd.push_back(1'($urandom)); end
        OP_ADDI: begin
          ph.push_back(10); rd.push_back(1'($urandom));
          ph.push_back(11); rd.push_back(1'($urandom));
        end
        default: repeat (4) begin ph.push_back(15); rd.push_back(1'($urandom)); end
      endcase
    end
    for (int i = 0; i < ph.size(); i++) begin
      if (i == abort_at) break;
      @(negedge clk);
      reset         = 1'b1;
      bus.mem_ready = rd[i];
      bus.Zero      = zero;
      bus.opc       = (i <= dec_idx) ? op : 6'($urandom);
      #1;
      n_vec++;
      if (bus.state_o !== 4'(ph[i])) begin
        n_err++;
        $display("FAIL state op%b i%0d: got %0d want %0d", op, i, bus.state_o, ph[i]);
      end
      n_vec++;
      if (obs_c !== exp_ctrl(ph[i], rd[i], pcwc)) begin
        n_err++;
        $display("FAIL ctrl op%b i%0d ph%0d: got %h want %h", op, i, ph[i], obs_c,
                 exp_ctrl(ph[i], rd[i], pcwc));
      end
      n_vec++;
      if (bus.fault !== 1'(ph[i] == 15)) begin
        n_err++;
        $display("FAIL fault op%b i%0d: got %b want %b", op, i, bus.fault, ph[i] == 15);
      end
      if (i == 0 || i == ph.size() - 1) begin
`ifdef MC_CTRL_PERF_EN
        e_c = m_cycle; e_i = m_instr; e_s = m_stall;
`else
        e_c = 0; e_i = 0; e_s = 0;
`endif
        n_vec++;
        if (bus.cycle_cnt !== e_c || bus.instr_cnt !== e_i || bus.stall_cnt !== e_s) begin
          n_err++;
          $display("FAIL counters op%b i%0d: got c%0d i%0d s%0d want c%0d i%0d s%0d", op, i,
                   bus.cycle_cnt, bus.instr_cnt, bus.stall_cnt, e_c, e_i, e_s);
        end
      end
      if (ph[i] != 15) begin
        m_cycle++;
        if (ph[i] == 0 && rd[i]) m_instr++;
        if ((ph[i] == 0 || ph[i] == 3 || ph[i] == 5) && !rd[i]) m_stall++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    run_instr(OP_R, 0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_lw_wait();
    do_reset(2);
    run_instr(OP_LW, 0, 2, 1'b0, -1, 1'b0);
    run_instr(OP_R, 0, 0, 1'b1, -1, 1'b0);
  endtask

  task automatic test_branch();
    run_instr(OP_BEQ, 0, 0, 1'b1, -1, 1'b0);
    run_instr(OP_BNE, 0, 0, 1'b1, -1, 1'b0);
    run_instr(OP_BEQ, 1, 0, 1'b0, -1, 1'b0);
    run_instr(OP_BNE, 0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_jump_addi();
    run_instr(OP_J, 0, 0, 1'b0, -1, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b1, -1, 1'b0);
    run_instr(OP_SW, 0, 0, 1'b0, -1, 1'b0);
  endtask

  // mem_ready arriving exactly when the wait counter reaches the limit still completes.
  task automatic test_wait_boundary();
    run_instr(OP_LW, TMO, TMO, 1'b0, -1, 1'b0);
    run_instr(OP_SW, TMO, TMO, 1'b1, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    for (int k = 0; k < 40; k++) begin
      run_instr(ops[$urandom_range(0, 6)],
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, TMO) : 0,
                $urandom_range(0, TMO), 1'($urandom), -1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    run_instr(OP_LW, 1, 3, 1'b0, 5, 1'b0);
    do_reset(1);
    run_instr(OP_SW, 0, 2, 1'b0, 4, 1'b0);
    do_reset(2);
    run_instr(OP_R, 0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_illegal();
    logic [5:0] ill [4];
    ill = '{6'b111111, 6'b000011, 6'b100001, 6'b001101};
    run_instr(ill[0], 0, 0, 1'b0, -1, 1'b0);
    do_reset(2);
    run_instr(ill[$urandom_range(1, 3)], 1, 0, 1'b1, -1, 1'b0);
    do_reset(2);
    run_instr(OP_ADDI, 0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_timeout();
    run_instr(OP_R, 0, 0, 1'b0, -1, 1'b1);
    do_reset(2);
    run_instr(OP_LW, 0, 1, 1'b0, -1, 1'b0);
  endtask

  initial begin
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opc       = 6'd0;
    bus.Zero      = 1'b0;
    m_cycle       = 0;
    m_instr       = 0;
    m_stall       = 0;
    test_reset();
    test_lw_wait();
    test_branch();
    test_jump_addi();
    test_wait_boundary();
    test_random();
    test_reset_mid();
    test_illegal();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
